// File: rtl/cpu_host_loader.sv
// Host-side loader: streams command words into CPU imem/dmem, runs the core for a counted
// number of cycles, and dumps dmem back out. Optional payload checksum under LOADER_CKSUM_EN.
module cpu_host_loader #(
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 12
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [63:0] m_data,
  output logic [63:0] imem_addr,
  output logic        imem_wen,
  output logic        imem_ren,
  output logic [31:0] imem_wdata,
  output logic [63:0] dmem_addr,
  output logic        dmem_wen,
  output logic        dmem_ren,
  output logic [63:0] dmem_wdata,
  input  logic [63:0] dmem_rdata,
  output logic        cpu_enable,
  output logic        busy,
  output logic        err,
  output logic [31:0] cksum
);

  typedef enum logic [3:0] {
    IDLE, LD_I, LD_D_LO, LD_D_HI, RUN_LEN, RUNNING, DUMP_RD, DUMP_WAIT, DUMP_OUT
  } state_t;

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [15:0]        r_idx;
  logic [31:0]        r_lo;
  logic [31:0]        r_run;
  logic [1:0]         r_lat;
  logic [63:0]        r_m_data;
  logic               r_err;
  logic               r_imem_wen, r_dmem_wen;
  logic [63:0]        r_imem_addr, r_dmem_addr, r_dmem_wdata;
  logic [31:0]        r_imem_wdata;

  logic [3:0]         w_cmd;
  logic [CNT_W-1:0]   w_hdr_n;
  logic               w_last;
  logic               w_lat_done;

  assign w_cmd      = s_data[31:28];
  assign w_hdr_n    = s_data[16 +: CNT_W];
  assign w_last     = (r_cnt == CNT_W'(1));
  assign w_lat_done = (r_lat == 2'(RD_LAT));

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (s_valid) begin
        case (w_cmd)
          4'd1:    if (w_hdr_n != '0) w_next = LD_I;
          4'd2:    if (w_hdr_n != '0) w_next = LD_D_LO;
          4'd3:    w_next = RUN_LEN;
          4'd4:    if (w_hdr_n != '0) w_next = DUMP_RD;
          default: w_next = IDLE;
        endcase
      end
      LD_I:      if (s_valid && w_last) w_next = IDLE;
      LD_D_LO:   if (s_valid) w_next = LD_D_HI;
      LD_D_HI:   if (s_valid) w_next = w_last ? IDLE : LD_D_LO;
      RUN_LEN:   if (s_valid) w_next = (s_data == 32'd0) ? IDLE : RUNNING;
      RUNNING:   if (r_run == 32'd1) w_next = IDLE;
      DUMP_RD:   w_next = DUMP_WAIT;
      DUMP_WAIT: if (w_lat_done) w_next = DUMP_OUT;
      DUMP_OUT:  if (m_ready) w_next = w_last ? IDLE : DUMP_RD;
      default:   w_next = IDLE;
    endcase
  end

  always_comb begin
    s_ready    = (r_state == IDLE) || (r_state == LD_I) || (r_state == LD_D_LO) ||
                 (r_state == LD_D_HI) || (r_state == RUN_LEN);
    busy       = (r_state != IDLE);
    cpu_enable = (r_state == RUNNING);
    dmem_ren   = (r_state == DUMP_RD);
    m_valid    = (r_state == DUMP_OUT);
    m_data     = r_m_data;
    dmem_addr  = (r_state == DUMP_RD) ? {45'd0, r_idx, 3'b000} : r_dmem_addr;
  end

  // Write strobes are one-cycle pulses; an async reset drops them before they land.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_lo         <= '0;
      r_run        <= '0;
      r_lat        <= '0;
      r_m_data     <= '0;
      r_err        <= 1'b0;
      r_imem_wen   <= 1'b0;
      r_dmem_wen   <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
    end else begin
      r_imem_wen <= 1'b0;
      r_dmem_wen <= 1'b0;
      case (r_state)
        IDLE: if (s_valid) begin
          r_cnt <= w_hdr_n;
          r_idx <= s_data[15:0];
          if (w_cmd == 4'd0 || w_cmd > 4'd4) r_err <= 1'b1;
        end
        LD_I: if (s_valid) begin
          r_imem_wen   <= 1'b1;
          r_imem_addr  <= {46'd0, r_idx, 2'b00};
          r_imem_wdata <= s_data;
          r_idx        <= r_idx + 16'd1;
          r_cnt        <= r_cnt - CNT_W'(1);
        end
        LD_D_LO: if (s_valid) r_lo <= s_data;
        LD_D_HI: if (s_valid) begin
          r_dmem_wen   <= 1'b1;
          r_dmem_addr  <= {45'd0, r_idx, 3'b000};
          r_dmem_wdata <= {s_data, r_lo};
          r_idx        <= r_idx + 16'd1;
          r_cnt        <= r_cnt - CNT_W'(1);
        end
        RUN_LEN: if (s_valid) r_run <= s_data;
        RUNNING: r_run <= r_run - 32'd1;
        DUMP_RD: r_lat <= 2'd1;
        DUMP_WAIT: begin
          if (w_lat_done) r_m_data <= dmem_rdata;
          else            r_lat    <= r_lat + 2'd1;
        end
        DUMP_OUT: if (m_ready) begin
          r_idx <= r_idx + 16'd1;
          r_cnt <= r_cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign imem_addr  = r_imem_addr;
  assign imem_wen   = r_imem_wen;
  assign imem_ren   = 1'b0;
  assign imem_wdata = r_imem_wdata;
  assign dmem_wen   = r_dmem_wen;
  assign dmem_wdata = r_dmem_wdata;
  assign err        = r_err;

`ifdef LOADER_CKSUM_EN
  logic [31:0] r_cksum;
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_cksum <= '0;
    end else if (r_state == IDLE) begin
      if (s_valid && (w_cmd == 4'd1 || w_cmd == 4'd2)) r_cksum <= '0;
    end else if (s_valid && (r_state == LD_I || r_state == LD_D_LO || r_state == LD_D_HI)) begin
      r_cksum <= r_cksum + s_data;
    end
  end
  assign cksum = r_cksum;
`else
  assign cksum = 32'd0;
`endif

endmodule

// File: tb/tb_cpu_host_loader.sv
// Directed + randomized bench for cpu_host_loader with a behavioural memory stand-in.
module tb_cpu_host_loader;
  logic        clk = 1'b0;
  logic        arst_n;
  logic        s_valid, s_ready, m_valid, m_ready;
  logic [31:0] s_data, imem_wdata, cksum;
  logic [63:0] m_data, imem_addr, dmem_addr, dmem_wdata, dmem_rdata;
  logic        imem_wen, imem_ren, dmem_wen, dmem_ren, cpu_enable, busy, err;

  cpu_host_loader #(.RD_LAT(1), .CNT_W(12)) dut (
    .clk(clk), .arst_n(arst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .imem_addr(imem_addr), .imem_wen(imem_wen), .imem_ren(imem_ren), .imem_wdata(imem_wdata),
    .dmem_addr(dmem_addr), .dmem_wen(dmem_wen), .dmem_ren(dmem_ren), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .cpu_enable(cpu_enable), .busy(busy), .err(err), .cksum(cksum)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  logic [95:0]  q_i[$];
  logic [127:0] q_d[$];
  logic [63:0]  mem[logic [63:0]];
  logic [63:0]  ref_d[int];
  logic [31:0]  pl[$];
  int en_cyc = 0, en_rise = 0, viol = 0;
  logic en_prev = 1'b0, ren_s = 1'b0;
  logic [63:0] addr_s = '0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory stand-in and protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (imem_wen) q_i.push_back({imem_addr, imem_wdata});
    if (dmem_wen) begin
      q_d.push_back({dmem_addr, dmem_wdata});
      mem[dmem_addr] = dmem_wdata;
    end
    if (cpu_enable) en_cyc++;
    if (cpu_enable && !en_prev) en_rise++;
    en_prev = cpu_enable;
    if (cpu_enable && (imem_wen || dmem_wen || dmem_ren || s_ready)) viol++;
    if (imem_ren) viol++;
    ren_s  = dmem_ren;
    addr_s = dmem_addr;
  end
  always @(posedge clk) if (ren_s) dmem_rdata <= mem.exists(addr_s) ? mem[addr_s] : 64'd0;

  task automatic idle(int n);
    s_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(logic [31:0] w);
    int t = 0;
    s_valid = 1'b1;
    s_data  = w;
    while (!s_ready && t < 100) begin @(negedge clk); t++; end
    chk("s_ready", 64'(s_ready), 64'(1));
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  function automatic logic [31:0] plsum();
    logic [31:0] s = 0;
    foreach (pl[k]) s += pl[k];
    return s;
  endfunction

  task automatic chk_cksum();
`ifdef LOADER_CKSUM_EN
    chk("cksum", 64'(cksum), 64'(plsum()));
`else
    chk("cksum", 64'(cksum), 64'(0));
`endif
  endtask

  task automatic load_i(logic [15:0] s);
    int n = pl.size();
    q_i.delete();
    send({4'h1, 12'(n), s});
    foreach (pl[k]) send(pl[k]);
    idle(3);
    chk("imem_cnt", 64'(q_i.size()), 64'(n));
    for (int k = 0; k < n && k < q_i.size(); k++) begin
      chk("imem_addr", q_i[k][95:32], 64'({16'(s + k), 2'b00}));
      chk("imem_dat", 64'(q_i[k][31:0]), 64'(pl[k]));
    end
    chk_cksum();
  endtask

  task automatic load_d(logic [15:0] s);
    int n = pl.size() / 2;
    q_d.delete();
    send({4'h2, 12'(n), s});
    foreach (pl[k]) send(pl[k]);
    idle(3);
    chk("dmem_cnt", 64'(q_d.size()), 64'(n));
    for (int k = 0; k < n; k++) begin
      ref_d[int'(16'(s + k))] = {pl[2*k+1], pl[2*k]};
      if (k < q_d.size()) begin
        chk("dmem_addr", q_d[k][127:64], 64'({16'(s + k), 3'b000}));
        chk("dmem_dat", q_d[k][63:0], {pl[2*k+1], pl[2*k]});
      end
    end
    chk_cksum();
  endtask

  task automatic run(int c);
    int t = 0;
    en_cyc = 0; en_rise = 0;
    send(32'h3000_0000);
    send(32'(c));
    while (busy && t < c + 50) begin @(negedge clk); t++; end
    chk("run_busy", 64'(busy), 64'(0));
    chk("run_cycles", 64'(en_cyc), 64'(c));
    chk("run_pulses", 64'(en_rise), 64'((c != 0) ? 1 : 0));
  endtask

  task automatic preload(int idx);
    logic [63:0] v = {$urandom, $urandom};
    mem[64'({16'(idx), 3'b000})] = v;
    ref_d[int'(16'(idx))] = v;
  endtask

  task automatic dump(logic [15:0] s, int n, bit rnd);
    int got = 0;
    bit pend = 0;
    logic [63:0] pdat = '0;
    send({4'h4, 12'(n), s});
    for (int t = 0; t < 40 * n + 50 && got < n; t++) begin
      m_ready = rnd ? 1'($urandom_range(0, 1)) : ~m_ready;
      if (pend) begin
        chk("dump_hold_vld", 64'(m_valid), 64'(1));
        chk("dump_hold_dat", m_data, pdat);
      end
      if (m_valid) begin
        if (m_ready) begin
          chk("dump_dat", m_data, ref_d[int'(16'(s + got))]);
          got++;
          pend = 0;
        end else begin
          pend = 1;
          pdat = m_data;
        end
      end
      @(negedge clk);
    end
    m_ready = 1'b0;
    chk("dump_cnt", 64'(got), 64'(n));
    idle(2);
    chk("dump_busy", 64'(busy), 64'(0));
    chk("dump_extra", 64'(m_valid), 64'(0));
  endtask

  initial begin
    arst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    #12;
    chk("rst_s_ready", 64'(s_ready), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_outs", 64'({m_valid, imem_wen, imem_ren, dmem_wen, dmem_ren, cpu_enable}), 64'(0));
    chk("rst_addr", imem_addr | dmem_addr | m_data | dmem_wdata, 64'(0));
    chk("rst_cksum", 64'(cksum), 64'(0));
    @(negedge clk);
    arst_n = 1'b1;
    idle(2);

    q_i.delete(); q_d.delete();
    send(32'hF000_0000);
    idle(3);
    chk("bad_err", 64'(err), 64'(1));
    chk("bad_busy", 64'(busy), 64'(0));
    chk("bad_noacc", 64'(q_i.size() + q_d.size()), 64'(0));

    pl = '{32'h0050_0093, 32'h0010_8113};
    load_i(16'h0004);
    chk("err_sticky", 64'(err), 64'(1));

    // Abort a doubleword load between its halves.
    q_d.delete();
    send(32'h2003_0010);
    send($urandom);
    #2 arst_n = 1'b0;
    #1;
    chk("arst_s_ready", 64'(s_ready), 64'(1));
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_err", 64'(err), 64'(0));
    chk("arst_outs", 64'({dmem_wen, imem_wen, cpu_enable, m_valid, dmem_ren}), 64'(0));
    @(negedge clk);
    arst_n = 1'b1;
    idle(2);
    chk("arst_nowrite", 64'(q_d.size()), 64'(0));

    pl = '{32'hDEAD_BEEF, 32'h0123_4567};
    load_d(16'hFFFF);
    pl = '{$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    load_d(16'hFFFD);

    q_i.delete(); q_d.delete();
    send(32'h1000_0005);
    idle(1);
    chk("n0_busy", 64'(busy), 64'(0));
    send(32'h4000_0000);
    idle(2);
    chk("n0_busy2", 64'(busy), 64'(0));
    chk("n0_noacc", 64'(q_i.size() + q_d.size()), 64'(0));

    for (int r = 0; r < 3; r++) begin
      int n = $urandom_range(1, 4);
      pl.delete();
      for (int k = 0; k < n; k++) pl.push_back($urandom);
      load_i((r == 0) ? 16'hFFFE : 16'($urandom));
    end

    run(20);
    run(0);
    run($urandom_range(1, 30));

    for (int k = 0; k < 4; k++) preload(k);
    m_ready = 1'b0;
    dump(16'h0000, 3, 1'b0);
    dump(16'hFFFD, 5, 1'b1);

    chk("invariant", 64'(viol), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
